// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - operation codes, FSM states and result type for the multiply/divide sequencer
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  // valid=0 marks a divide by zero, whose commit must leave HI/LO untouched
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        valid;
  } md_result_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_alu.sv
// rtl/md_alu.sv - combinational 64-bit product and quotient/remainder for the md sequencer
module md_alu
  import md_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output md_result_t  result
);

  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no special case
  always_comb begin
    result = '0;
    prod   = '0;
    a_mag  = '0;
    b_mag  = '0;
    quo    = '0;
    rem    = '0;
    case (op)
      MD_MULT: begin
        prod   = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        result = {prod[63:32], prod[31:0], 1'b1};
      end
      MD_MULTU: begin
        prod   = {32'd0, rs} * {32'd0, rt};
        result = {prod[63:32], prod[31:0], 1'b1};
      end
      MD_DIV: begin
        if (rt != 32'd0) begin
          a_mag  = rs[31] ? (32'd0 - rs) : rs;
          b_mag  = rt[31] ? (32'd0 - rt) : rt;
          quo    = a_mag / b_mag;
          rem    = a_mag % b_mag;
          result.lo    = (rs[31] ^ rt[31]) ? (32'd0 - quo) : quo;
          result.hi    = rs[31] ? (32'd0 - rem) : rem;
          result.valid = 1'b1;
        end
      end
      MD_DIVU: begin
        if (rt != 32'd0) begin
          result.lo    = rs / rt;
          result.hi    = rs % rt;
          result.valid = 1'b1;
        end
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle multiply/divide sequencer owning the architectural HI/LO
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES)) + 1;

  md_state_e   state;
  logic [CNT_W-1:0] cnt;
  md_result_t  res;
  md_result_t  pend;

  md_alu u_alu (
    .op     (md_op_e'(md_op)),
    .rs     (rs_val),
    .rt     (rt_val),
    .result (res)
  );

  // Result is captured at start so operands may change freely while the sequence runs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      pend  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (md_op_e'(md_op))
              MD_MULT, MD_MULTU: begin
                pend  <= res;
                cnt   <= CNT_W'(MULT_CYCLES - 1);
                state <= S_RUN;
                busy  <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                pend  <= res;
                cnt   <= CNT_W'(DIV_CYCLES - 1);
                state <= S_RUN;
                busy  <= 1'b1;
              end
              MD_MTHI: hi <= rs_val;
              MD_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (cnt == '0) begin
            if (pend.valid) begin
              hi <= pend.hi;
              lo <= pend.lo;
            end
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - self-checking bench for md_sequencer with a reference model
module tb_md_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: arithmetic straight from the instruction definitions
  function automatic void calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [63:0] r, output bit ok);
    logic signed [63:0] sa, sb, q, m;
    logic [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ok = 1'b1;
    r  = '0;
    case (op)
      3'd1: r = sa * sb;
      3'd2: r = ua * ub;
      3'd3: if (b == 0) ok = 1'b0; else begin q = sa / sb; m = sa % sb; r = {m[31:0], q[31:0]}; end
      3'd4: if (b == 0) ok = 1'b0; else r = {32'(ua % ub), 32'(ua / ub)};
      default: ok = 1'b0;
    endcase
  endfunction

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] p_res = '0;
  bit          p_ok = 1'b0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_ok) {m_hi, m_lo} = p_res;
    end else if (start) begin
      case (md_op)
        3'd1, 3'd2: begin calc(md_op, rs_val, rt_val, p_res, p_ok); m_left = MULT_N; end
        3'd3, 3'd4: begin calc(md_op, rs_val, rt_val, p_res, p_ok); m_left = DIV_N; end
        3'd5: m_hi = rs_val;
        3'd6: m_lo = rs_val;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", {31'd0, busy}, {31'd0, m_left > 0});
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles", busy, n);
    end
  endtask

  int n;

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = '0; rt_val = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    count_busy(n);
    chk("mult_cycles", n, MULT_N);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    count_busy(n);
    chk("div_cycles", n, DIV_N);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    issue(3'd4, 32'hFFFFFFF9, 32'd2);
    count_busy(n);
    chk("divu_lo", lo, 32'h7FFFFFFC);
    chk("divu_hi", hi, 32'd1);

    issue(3'd5, 32'h11, 32'd0);
    issue(3'd6, 32'h22, 32'd0);
    issue(3'd3, 32'd1234, 32'd0);
    count_busy(n);
    chk("div0_cycles", n, DIV_N);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    count_busy(n);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'd0);

    issue(3'd5, 32'hDEADBEEF, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'hDEADBEEF);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    count_busy(n);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'd1);

    issue(3'd0, 32'h5, 32'h5);
    chk("none_busy", {31'd0, busy}, 32'd0);
    issue(3'd7, 32'h5, 32'h5);
    chk("undef_busy", {31'd0, busy}, 32'd0);
    chk("undef_hi", hi, 32'hFFFFFFFE);

    issue(3'd3, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (15) @(negedge clk);
    chk("abort_nocommit_lo", lo, 32'd0);

    reset = 1'b1;
    issue(3'd1, 32'd2, 32'd3);
    reset = 1'b0;
    chk("rst_wins_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("rst_wins_lo", lo, 32'd0);

    // start held high through a whole run, then once more in the first idle cycle
    issue(3'd1, 32'd6, 32'd7);
    start = 1'b1; md_op = 3'd4; rs_val = 32'd100; rt_val = 32'd3;
    count_busy(n);
    chk("hold_cycles", n, MULT_N);
    chk("hold_lo", lo, 32'd42);
    chk("hold_hi", hi, 32'd0);
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    count_busy(n);
    chk("b2b_cycles", n, DIV_N);
    chk("b2b_lo", lo, 32'd33);
    chk("b2b_hi", hi, 32'd1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
